cdr_phase_detector: RTL and testbench

Early/late phase detector and loop filter for the CDR. It captures the sliced chip stream at the three per-symbol sampling strobes from the CDR timing counter and, on the evaluation strobe, emits the recovered symbol plus transition and early/late flags. It integrates the early/late votes in a saturating accumulator. On the frequency-sync strobe it returns a corrected samples-per-symbol value (`o_nb_P`) to the timing counter and divider.

---
 rtl/cdr_phase_detector.sv | 108 ++++++++++
 tb/tb_cdr_phase_detector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_phase_detector.sv
// cdr_phase_detector: early/late phase detector with a saturating vote
// accumulator that requests a one-period samples-per-symbol correction.
module cdr_phase_detector #(
    parameter int NB_P_NOM = 24,
    parameter int ACC_W    = 4,
    parameter int THRESH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data,
    input  logic       i_en_d,
    input  logic       i_en_m,
    input  logic       i_en_f,
    input  logic       i_en,
    input  logic       i_en_freq_synch,
    output logic [5:0] o_nb_P,
    output logic       o_data,
    output logic       o_data_valid,
    output logic       o_T,
    output logic       o_early,
    output logic       o_late
);

    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;

    logic                    s_d;
    logic                    s_m;
    logic                    s_f;
    logic                    s_pm;
    logic                    first;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    int                      acc_i;
    logic                    maj;
    logic                    trans;
    logic                    early;
    logic                    late;
    logic                    hit_hi;
    logic                    hit_lo;
    logic [5:0]              nb_nxt;

    always_comb begin
        acc_i  = int'(acc);
        maj    = (s_d & s_m) | (s_d & s_f) | (s_m & s_f);
        trans  = (s_pm ^ s_m) & ~first;
        early  = trans & (s_d ^ s_m);
        late   = trans & ~(s_d ^ s_m);
        hit_hi = acc_i >= THRESH;
        hit_lo = acc_i <= -THRESH;

        acc_nxt = acc;
        if (i_en) begin
            if (early && acc_i < ACC_MAX)
                acc_nxt = acc + ACC_W'(1);
            else if (late && acc_i > -ACC_MAX)
                acc_nxt = acc - ACC_W'(1);
        end

        // a firing correction overrides this cycle's vote
        nb_nxt = o_nb_P;
        if (i_en_freq_synch) begin
            unique case (1'b1)
                hit_hi: begin
                    nb_nxt  = 6'(NB_P_NOM + 1);
                    acc_nxt = '0;
                end
                hit_lo: begin
                    nb_nxt  = 6'(NB_P_NOM - 1);
                    acc_nxt = '0;
                end
                default: nb_nxt = 6'(NB_P_NOM);
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            s_d          <= 1'b0;
            s_m          <= 1'b0;
            s_f          <= 1'b0;
            s_pm         <= 1'b0;
            first        <= 1'b1;
            acc          <= '0;
            o_nb_P       <= 6'(NB_P_NOM);
            o_data       <= 1'b0;
            o_data_valid <= 1'b0;
            o_T          <= 1'b0;
            o_early      <= 1'b0;
            o_late       <= 1'b0;
        end else begin
            if (i_en_d) s_d <= i_data;
            if (i_en_m) s_m <= i_data;
            if (i_en_f) s_f <= i_data;
            if (i_en) begin
                o_data  <= maj;
                o_T     <= trans;
                o_early <= early;
                o_late  <= late;
                s_pm    <= s_m;
                first   <= 1'b0;
            end
            o_data_valid <= i_en;
            acc          <= acc_nxt;
            o_nb_P       <= nb_nxt;
        end
    end

endmodule

// File: tb/tb_cdr_phase_detector.sv
// tb_cdr_phase_detector: randomized symbol periods checked via a
// scoreboard against a symbol-level reference model.
`timescale 1ns/1ps
module tb_cdr_phase_detector;

    localparam int NOM = 24;
    localparam int SAT = 7;
    localparam int THR = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_data = 1'b0;
    logic       i_en_d = 1'b0;
    logic       i_en_m = 1'b0;
    logic       i_en_f = 1'b0;
    logic       i_en = 1'b0;
    logic       i_en_freq_synch = 1'b0;
    logic [5:0] o_nb_P;
    logic       o_data;
    logic       o_data_valid;
    logic       o_T;
    logic       o_early;
    logic       o_late;

    cdr_phase_detector #(
        .NB_P_NOM(NOM),
        .ACC_W   (4),
        .THRESH  (THR)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_data         (i_data),
        .i_en_d         (i_en_d),
        .i_en_m         (i_en_m),
        .i_en_f         (i_en_f),
        .i_en           (i_en),
        .i_en_freq_synch(i_en_freq_synch),
        .o_nb_P         (o_nb_P),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .o_T            (o_T),
        .o_early        (o_early),
        .o_late         (o_late)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic d;
        logic t;
        logic e;
        logic l;
    } res_t;

    res_t res_q[$];
    int   nb_q[$];
    int   checks = 0;
    int   errors = 0;

    // symbol-level reference state
    int m_d, m_m, m_f, m_pm, m_acc;
    bit m_first;
    bit sym;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d = 0; m_m = 0; m_f = 0; m_pm = 0;
        m_acc = 0; m_first = 1;
    endtask

    task automatic model_cycle(input bit rst_n, input bit din,
                               input bit sd, input bit sm, input bit sf,
                               input bit en, input bit fs);
        res_t r;
        int   vote;
        bit   t;
        vote = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (en) begin
            t   = !m_first && (m_pm != m_m);
            r.d = (m_d + m_m + m_f) >= 2;
            r.t = t;
            r.e = t && (m_d != m_m);
            r.l = t && (m_d == m_m);
            res_q.push_back(r);
            vote = r.e ? 1 : (r.l ? -1 : 0);
            m_pm = m_m;
            m_first = 0;
        end
        if (fs) begin
            if (m_acc >= THR) begin
                nb_q.push_back(NOM + 1);
                m_acc = 0;
                vote = 0;
            end else if (m_acc <= -THR) begin
                nb_q.push_back(NOM - 1);
                m_acc = 0;
                vote = 0;
            end else begin
                nb_q.push_back(NOM);
            end
        end
        if (m_acc + vote >= -SAT && m_acc + vote <= SAT)
            m_acc += vote;
        if (sd) m_d = din;
        if (sm) m_m = din;
        if (sf) m_f = din;
    endtask

    task automatic cyc(input bit rst_n, input bit din,
                       input bit sd, input bit sm, input bit sf,
                       input bit en, input bit fs);
        @(posedge i_clk);
        #1;
        i_rst = rst_n;
        i_data = din;
        i_en_d = sd;
        i_en_m = sm;
        i_en_f = sf;
        i_en = en;
        i_en_freq_synch = fs;
        model_cycle(rst_n, din, sd, sm, sf, en, fs);
    endtask

    task automatic period(input int len, input logic [15:0] wave,
                          input bit fsync, input bit fs_en,
                          input int rst_at);
        int pm, pf, pe, pfs;
        pm = len / 2;
        pf = len - 3;
        pe = len - 2;
        pfs = fs_en ? pe : len - 1;
        for (int c = 0; c < len; c++)
            cyc(c != rst_at, wave[c], c == 1, c == pm, c == pf,
                c == pe, fsync && c == pfs);
    endtask

    function automatic logic [15:0] mkwave(input bit prev, input bit nxt,
                                           input int e);
        logic [15:0] w;
        for (int c = 0; c < 16; c++)
            w[c] = (c < e) ? prev : nxt;
        return w;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < 3; i++)
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        sym = 0;
    endtask

    task automatic early_p(input bit fsync);
        period(12, mkwave(sym, !sym, 3), fsync, 0, -1);
        sym = !sym;
    endtask

    task automatic late_p(input bit fsync);
        period(12, mkwave(sym, !sym, 0), fsync, 0, -1);
        sym = !sym;
    endtask

    task automatic const_p(input bit fsync);
        period(12, mkwave(sym, sym, 0), fsync, 0, -1);
    endtask

    // monitor side
    logic en_s = 1'b0;
    logic fs_s = 1'b0;
    logic rst_s = 1'b0;
    res_t last = '0;
    int   cur_nb = NOM;

    always @(posedge i_clk) begin
        en_s  <= i_en && i_rst;
        fs_s  <= i_en_freq_synch && i_rst;
        rst_s <= !i_rst;
    end

    always @(negedge i_clk) begin
        res_t exp;
        if (rst_s) begin
            check("rst_out", int'({o_data, o_data_valid, o_T, o_early, o_late}), 0);
            check("rst_nb", int'(o_nb_P), NOM);
            last = '0;
            cur_nb = NOM;
        end else begin
            check("valid", int'(o_data_valid), int'(en_s));
            if (o_data_valid) begin
                if (res_q.size() == 0) begin
                    check("extra_eval", 1, 0);
                end else begin
                    exp = res_q.pop_front();
                    check("eval", int'({o_data, o_T, o_early, o_late}), int'(exp));
                    last = exp;
                end
            end else begin
                check("hold", int'({o_data, o_T, o_early, o_late}), int'(last));
            end
            if (fs_s) begin
                if (nb_q.size() == 0)
                    check("extra_nb", 1, 0);
                else
                    cur_nb = nb_q.pop_front();
            end
            check("nb", int'(o_nb_P), cur_nb);
        end
    end

    initial begin
        int          len, e, k, rst_at;
        bit          nxt, fsync, fs_en;
        logic [15:0] w;
        model_reset();
        do_reset();

        sym = 1;
        for (int i = 0; i < 10; i++) const_p(1);
        for (int i = 0; i < 8; i++) early_p(1);
        for (int i = 0; i < 8; i++) late_p(1);

        do_reset();
        period(12, 16'hFFBF, 0, 0, -1);
        sym = 1;
        for (int i = 0; i < 10; i++) early_p(0);
        const_p(1);
        for (int i = 0; i < 10; i++) early_p(0);
        for (int i = 0; i < 3; i++) late_p(0);
        const_p(1);

        do_reset();
        for (int i = 0; i < 5; i++) early_p(0);
        period(12, mkwave(sym, !sym, 3), 1, 1, -1);
        sym = !sym;
        for (int i = 0; i < 3; i++) early_p(0);
        const_p(1);

        period(12, mkwave(sym, !sym, 3), 1, 0, 7);
        sym = !sym;
        early_p(1);

        for (int p = 0; p < 250; p++) begin
            len = $urandom_range(8, 16);
            nxt = 1'($urandom_range(0, 1));
            e = $urandom_range(0, len - 1);
            w = mkwave(sym, nxt, e);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, len - 1);
                w[k] = ~w[k];
            end
            fsync = $urandom_range(0, 2) != 0;
            fs_en = $urandom_range(0, 3) == 0;
            rst_at = ($urandom_range(0, 49) == 0) ? $urandom_range(0, len - 1) : -1;
            period(len, w, fsync, fs_en, rst_at);
            sym = nxt;
        end

        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("res_q_drained", res_q.size(), 0);
        check("nb_q_drained", nb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
